gate_test_seq: RTL and testbench

GATE_TEST_SEQ -- requirements
Module: gate_test_seq

---
 rtl/gate_test_pkg.sv | 31 +++
 rtl/settle_timer.sv | 26 ++
 rtl/gate_test_seq.sv | 138 +++++++++++++
 tb/tb_gate_test_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the AND-gate test sequencer.
// Covers the state encoding, the vector table, the expected truth table and the settle bounds.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Entry i is {a,b} for vector i: 00, 01, 10, 11
    localparam logic [7:0] VEC_TABLE = 8'b11_10_01_00;
    // 2-input AND truth table, indexed by {a,b}
    localparam logic [3:0] EXP_FUNC  = 4'b1000;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        return VEC_TABLE[{idx, 1'b0} +: 2];
    endfunction

    // Timer reload value; out-of-range settings are clamped into the legal window
    function automatic logic [3:0] settle_load(input int cycles);
        int c;
        c = (cycles < SETTLE_MIN) ? SETTLE_MIN : ((cycles > SETTLE_MAX) ? SETTLE_MAX : cycles);
        return 4'(c - 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle down-counter: loads a hold count, decrements while enabled,
// and flags terminal count at zero.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/gate_test_seq.sv
// Walks {a,b} through 00..11, samples the gate output c after each settle window, and counts mismatches.
// Optional GATE_TEST_FAILMAP_EN adds the per-vector fail_vec output.
//
// state  | meaning
// IDLE   | waiting for start, stimulus parked at 00
// SETTLE | current vector held while the gate settles
// SAMPLE | c compared against the AND of the applied vector
// DONE   | one-cycle done pulse, pass result published
module gate_test_seq
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
`ifdef GATE_TEST_FAILMAP_EN
    output logic [3:0] fail_vec,
`endif
    output logic [1:0] vec_idx
);

    localparam logic [3:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

    state_t     state, state_nxt;
    logic [1:0] ab_nxt;
    logic [1:0] vec_nxt;
    logic [2:0] err_nxt;
    logic       pass_nxt;
    logic       tmr_load;
    logic       tmr_zero;
    logic       mismatch;
`ifdef GATE_TEST_FAILMAP_EN
    logic [3:0] fail_nxt;
`endif

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .en       (state == ST_SETTLE),
        .zero     (tmr_zero)
    );

    assign mismatch = (c != EXP_FUNC[{a, b}]);

    always_comb begin
        state_nxt = state;
        ab_nxt    = {a, b};
        vec_nxt   = vec_idx;
        err_nxt   = err_cnt;
        pass_nxt  = pass;
        tmr_load  = 1'b0;
`ifdef GATE_TEST_FAILMAP_EN
        fail_nxt  = fail_vec;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    vec_nxt   = 2'd0;
                    ab_nxt    = vec_ab(2'd0);
                    err_nxt   = 3'd0;
                    pass_nxt  = 1'b0;
                    tmr_load  = 1'b1;
`ifdef GATE_TEST_FAILMAP_EN
                    fail_nxt  = 4'd0;
`endif
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_nxt = err_cnt + 3'd1;
`ifdef GATE_TEST_FAILMAP_EN
                    fail_nxt[vec_idx] = 1'b1;
`endif
                end
                if (vec_idx == 2'd3) begin
                    state_nxt = ST_DONE;
                    ab_nxt    = 2'b00;
                    pass_nxt  = (err_nxt == 3'd0);
                end else begin
                    state_nxt = ST_SETTLE;
                    vec_nxt   = vec_idx + 2'd1;
                    ab_nxt    = vec_ab(vec_idx + 2'd1);
                    tmr_load  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 3'd0;
            vec_idx  <= 2'd0;
`ifdef GATE_TEST_FAILMAP_EN
            fail_vec <= 4'd0;
`endif
        end else begin
            state    <= state_nxt;
            {a, b}   <= ab_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
            pass     <= pass_nxt;
            err_cnt  <= err_nxt;
            vec_idx  <= vec_nxt;
`ifdef GATE_TEST_FAILMAP_EN
            fail_vec <= fail_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: a behavioural gate model feeds c, and a scoreboard of
// expected pass results is checked against each done pulse.
module tb_gate_test_seq;

    typedef struct {
        logic [2:0] err;
        logic       pass;
        logic [3:0] fv;
    } exp_t;

    localparam int MODE_AND = 0;
    localparam int MODE_SA0 = 1;
    localparam int MODE_SA1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic a0, b0, c0, busy0, done0, pass0;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [1:0] vec0, vec1;
`ifdef GATE_TEST_FAILMAP_EN
    logic [3:0] fv0, fv1;
`endif
    int mode0 = MODE_AND;
    int total = 0;
    int bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic gate_model(input int mode, input logic x, input logic y);
        if (mode == MODE_SA0) return 1'b0;
        if (mode == MODE_SA1) return 1'b1;
        return x & y;
    endfunction

    function automatic exp_t expect_pass(input int mode);
        exp_t e;
        logic [1:0] v;
        e.err = 3'd0;
        e.fv  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (gate_model(mode, v[1], v[0]) != (v[1] & v[0])) begin
                e.err = e.err + 3'd1;
                e.fv[i] = 1'b1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    always_comb c0 = gate_model(mode0, a0, b0);
    always_comb c1 = gate_model(MODE_AND, a1, b1);

    gate_test_seq #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
`ifdef GATE_TEST_FAILMAP_EN
        .fail_vec(fv0),
`endif
        .vec_idx(vec0)
    );

    gate_test_seq #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
`ifdef GATE_TEST_FAILMAP_EN
        .fail_vec(fv1),
`endif
        .vec_idx(vec1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({a0, b0, busy0, done0, pass0, err0, vec0} !== 10'd0) begin
            bad++;
            $display("FAIL reset_dut0 got=%b want=0", {a0, b0, busy0, done0, pass0, err0, vec0});
        end
        total++;
        if ({a1, b1, busy1, done1, pass1, err1, vec1} !== 10'd0) begin
            bad++;
            $display("FAIL reset_dut1 got=%b want=0", {a1, b1, busy1, done1, pass1, err1, vec1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one pass on the SETTLE_CYCLES=2 instance; n counts edges after the start edge
    task automatic run_pass(input int mode, input string name);
        exp_t e;
        int n;
        bit seen;
        logic [1:0] v;
        mode0 = mode;
        @(negedge clk);
        start0 = 1'b1;
        sb.push_back(expect_pass(mode));
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            if (done0) begin
                seen = 1;
            end else if (n < 12) begin
                v = 2'(n / 3);
                total++;
                if ({busy0, vec0, a0, b0} !== {1'b1, v, v}) begin
                    bad++;
                    $display("FAIL %s_walk edge=%0d got=%b want=%b", name, n,
                             {busy0, vec0, a0, b0}, {1'b1, v, v});
                end
            end
            if (!seen) begin
                @(negedge clk);
                n++;
            end
        end
        total++;
        if (!seen || n != 12) begin
            bad++;
            $display("FAIL %s_latency done_edge=%0d seen=%0d want=12", name, n, seen);
        end
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({err0, pass0} !== {e.err, e.pass}) begin
                bad++;
                $display("FAIL %s_result err=%0d pass=%b want err=%0d pass=%b", name, err0, pass0, e.err, e.pass);
            end
`ifdef GATE_TEST_FAILMAP_EN
            total++;
            if (fv0 !== e.fv) begin
                bad++;
                $display("FAIL %s_failvec got=%b want=%b", name, fv0, e.fv);
            end
`endif
            @(negedge clk);
            total++;
            if ({done0, busy0, err0, pass0} !== {2'b00, e.err, e.pass}) begin
                bad++;
                $display("FAIL %s_hold got=%b want=%b", name, {done0, busy0, err0, pass0}, {2'b00, e.err, e.pass});
            end
        end
    endtask

    task automatic test_start_held();
        exp_t e;
        int n;
        int dones = 0;
        bit seen2 = 0;
        mode0 = MODE_AND;
        @(negedge clk);
        start0 = 1'b1;
        sb.push_back(expect_pass(MODE_AND));
        sb.push_back(expect_pass(MODE_AND));
        for (n = 0; n < 60 && !seen2; n++) begin
            @(negedge clk);
            if (n == 19) start0 = 1'b0;
            if (done0) begin
                if (n < 20) dones++;
                else seen2 = 1;
                e = sb.pop_front();
                total++;
                if ({err0, pass0} !== {e.err, e.pass}) begin
                    bad++;
                    $display("FAIL held_result edge=%0d err=%0d pass=%b want err=%0d pass=%b", n, err0, pass0, e.err, e.pass);
                end
            end
            if (n == 13) begin
                total++;
                if (busy0 !== 1'b0) begin
                    bad++;
                    $display("FAIL held_idle_gap busy=%b want=0", busy0);
                end
            end
            if (n == 14) begin
                total++;
                if ({busy0, vec0, a0, b0} !== 5'b1_00_00) begin
                    bad++;
                    $display("FAIL held_restart got=%b want=10000", {busy0, vec0, a0, b0});
                end
            end
        end
        total++;
        if (dones != 1 || !seen2) begin
            bad++;
            $display("FAIL held_done_count first_window=%0d second_seen=%0d want 1 and 1", dones, seen2);
        end
        start0 = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        int n = 0;
        bit bad_done = 0;
        mode0 = MODE_SA1;
        @(negedge clk);
        start0 = 1'b1;
        sb.push_back(expect_pass(MODE_SA1));
        @(negedge clk);
        start0 = 1'b0;
        while (vec0 != 2'd2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (vec0 !== 2'd2 || err0 !== 3'd2 || {a0, b0} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_pre vec=%0d err=%0d ab=%b want vec=2 err=2 ab=10", vec0, err0, {a0, b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a0, b0, busy0, done0, pass0, err0, vec0} !== 10'd0) begin
            bad++;
            $display("FAIL midreset_async got=%b want=0", {a0, b0, busy0, done0, pass0, err0, vec0});
        end
        void'(sb.pop_back());
        repeat (3) begin
            @(negedge clk);
            if (done0 || busy0) bad_done = 1;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done0 || busy0) bad_done = 1;
        end
        total++;
        if (bad_done) begin
            bad++;
            $display("FAIL midreset_no_done saw done/busy=1 want none");
        end
        run_pass(MODE_AND, "after_reset");
    endtask

    task automatic test_settle1();
        int n = 0;
        bit seen = 0;
        logic [1:0] v;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (!seen && n < 40) begin
            if (done1) begin
                seen = 1;
            end else if (n < 8) begin
                v = 2'(n / 2);
                total++;
                if ({busy1, vec1, a1, b1} !== {1'b1, v, v}) begin
                    bad++;
                    $display("FAIL s1_walk edge=%0d got=%b want=%b", n, {busy1, vec1, a1, b1}, {1'b1, v, v});
                end
            end
            if (!seen) begin
                @(negedge clk);
                n++;
            end
        end
        total++;
        if (!seen || n != 8 || {err1, pass1} !== 4'b000_1) begin
            bad++;
            $display("FAIL s1_done edge=%0d seen=%0d err=%0d pass=%b want edge=8 err=0 pass=1", n, seen, err1, pass1);
        end
    endtask

    initial begin
        test_reset();
        run_pass(MODE_AND, "and_ok");
        run_pass(MODE_SA0, "stuck0");
        run_pass(MODE_SA1, "stuck1");
        run_pass(MODE_AND, "recover");
        test_start_held();
        test_reset_mid_pass();
        test_settle1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
